// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI register bank.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } spi_state_e;

  localparam int CMD_W  = 8;
  // R/W is the first bit on the wire, so it lands in the MSB of the command byte
  localparam int RW_BIT = 7;
  localparam int ADDR_W = 7;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with rise/fall detection against a one-cycle-delayed copy.
module spi_sync_edge #(
  parameter logic RESET_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic valid_o
);

  logic       meta_q;
  logic       sync_q;
  logic       dly_q;
  logic [1:0] fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_LVL;
      sync_q <= RESET_LVL;
      dly_q  <= RESET_LVL;
      fill_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
      fill_q <= {fill_q[0], 1'b1};
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~dly_q;
  assign fall_o  = ~sync_q & dly_q;
  // High once sync_q holds a real sample rather than the reset level
  assign valid_o = fill_q[1];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI peripheral exposing NUM_REGS words of DATA_W bits; writes commit on ncs rise.
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int                          NUM_REGS  = 5,
  parameter int                          DATA_W    = 8,
  parameter logic                        CPOL      = 1'b0,
  parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         copi,
  input  logic                         ncs,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FRAME_LEN = CMD_W + DATA_W;
  localparam int CNT_MAX   = FRAME_LEN + 1;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  logic sclk_lvl, sclk_rise, sclk_fall, sclk_vld;
  logic copi_lvl, copi_rise, copi_fall, copi_vld;
  logic ncs_lvl,  ncs_rise,  ncs_fall,  ncs_vld;

  spi_sync_edge #(.RESET_LVL(CPOL)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_i(sclk),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall), .valid_o(sclk_vld));
  spi_sync_edge #(.RESET_LVL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .async_i(copi),
    .level_o(copi_lvl), .rise_o(copi_rise), .fall_o(copi_fall), .valid_o(copi_vld));
  spi_sync_edge #(.RESET_LVL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .async_i(ncs),
    .level_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall), .valid_o(ncs_vld));

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, sclk_vld, copi_rise, copi_fall, copi_vld};

  spi_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d, cmd_full;
  logic [DATA_W-1:0]   rx_q, rx_d, tx_q, tx_d, rd_word;
  logic [ADDR_W-1:0]   rd_addr, commit_addr_q, commit_addr_d, wr_addr_q;
  logic [DATA_W-1:0]   commit_data_q, commit_data_d;
  logic                armed_q, armed_d, commit_q, commit_d, err_q, err_d;
  logic                wr_strobe_q, frame_err_q;
  logic                sample, in_tx;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  assign sample   = sclk_rise && !ncs_lvl && (state_q != ST_IDLE);
  assign cmd_full = {cmd_q[CMD_W-2:0], copi_lvl};
  assign rd_addr  = cmd_full[ADDR_W-1:0];
  assign in_tx    = (state_q == ST_DATA) || (state_q == ST_DRAIN);

  // Out-of-range addresses match no word and read back as zero
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_word = regs_q[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_d         = cmd_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    commit_d      = 1'b0;
    err_d         = 1'b0;
    commit_addr_d = commit_addr_q;
    commit_data_d = commit_data_q;
    // A fall only counts once ncs has been genuinely seen high after reset
    armed_d       = armed_q | (ncs_vld & ncs_lvl);

    if (ncs_rise) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      if (cnt_q == CNT_W'(FRAME_LEN)) begin
        commit_d      = cmd_q[RW_BIT] && addr_ok(cmd_q[ADDR_W-1:0]);
        commit_addr_d = cmd_q[ADDR_W-1:0];
        commit_data_d = rx_q;
      end else if (cnt_q != '0) begin
        err_d = 1'b1;
      end
    end else if (ncs_fall && armed_q) begin
      // Any fall, even outside IDLE, restarts the frame from scratch
      state_d = ST_CMD;
      cnt_d   = '0;
      cmd_d   = '0;
      rx_d    = '0;
      tx_d    = '0;
    end else if (sample) begin
      if (cnt_q != CNT_W'(CNT_MAX)) cnt_d = cnt_q + 1'b1;
      case (state_q)
        ST_CMD: begin
          cmd_d = cmd_full;
          if (cnt_q == CNT_W'(CMD_W - 1)) begin
            state_d = ST_DATA;
            tx_d    = cmd_full[RW_BIT] ? '0 : rd_word;
          end
        end
        ST_DATA: begin
          rx_d = {rx_q[DATA_W-2:0], copi_lvl};
          if (cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = ST_DRAIN;
        end
        default: ;
      endcase
    end else if (sclk_fall && !ncs_lvl && in_tx && (cnt_q > CNT_W'(CMD_W))) begin
      // The fall right after latching keeps the MSB for the first data sample
      tx_d = {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cmd_q         <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      armed_q       <= 1'b0;
      commit_q      <= 1'b0;
      commit_addr_q <= '0;
      commit_data_q <= '0;
      err_q         <= 1'b0;
      wr_strobe_q   <= 1'b0;
      wr_addr_q     <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      armed_q       <= armed_d;
      commit_q      <= commit_d;
      commit_addr_q <= commit_addr_d;
      commit_data_q <= commit_data_d;
      err_q         <= err_d;
      wr_strobe_q   <= commit_q;
      frame_err_q   <= err_q;
      if (commit_q) wr_addr_q <= commit_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
    end else if (commit_q) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_addr_q == ADDR_W'(i)) regs_q[i] <= commit_data_q;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_out
    assign regs_out[gi*DATA_W +: DATA_W] = regs_q[gi];
  end

  assign cipo_oe   = in_tx && !cmd_q[RW_BIT] && !ncs_lvl;
  assign cipo      = cipo_oe & tx_q[DATA_W-1];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule
